// File: rtl/uart_fifo_if.sv
// Byte-stream handshake bundle between a FIFO and its producer/consumer.
// The master drives the requests; the slave (the FIFO) returns data and status.
interface uart_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              wr;
    logic [DATA_W-1:0] w_data;
    logic              rd;
    logic [DATA_W-1:0] r_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, w_data, rd,
        input  r_data, empty, full, count, overflow, underflow
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO between the UART and the processor.
// It tracks occupancy and keeps sticky overflow/underflow flags for debug.
module uart_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input logic         clk,
    input logic         reset,
    uart_fifo_if.slave  bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(Depth);

    logic [DATA_W-1:0] mem [Depth];
    logic [ADDR_W-1:0] w_ptr_q, r_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q;
    logic              overflow_q, underflow_q;
    logic              do_wr, do_rd;
    logic              set_overflow, set_underflow;

    always_comb begin
        // A write into a full FIFO is only legal when a pop frees the slot on the same edge.
        do_wr         = bus.wr && (!full_q || bus.rd);
        do_rd         = bus.rd && !empty_q;
        set_overflow  = bus.wr && !bus.rd && full_q;
        set_underflow = bus.rd && !bus.wr && empty_q;
        count_d       = count_q;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (do_wr) w_ptr_q <= w_ptr_q + 1'b1;
            if (do_rd) r_ptr_q <= r_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DepthCnt);
            empty_q <= (count_d == '0);
            if (set_overflow)  overflow_q  <= 1'b1;
            if (set_underflow) underflow_q <= 1'b1;
        end
    end

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && do_wr) mem[w_ptr_q] <= bus.w_data;
    end

    assign bus.r_data    = mem[r_ptr_q];
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: expected bytes go to a queue, a monitor checks each pop.
// Status outputs are checked against hand-computed values after each edge.
module tb_uart_fifo;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    uart_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    uart_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Monitor: a pop is presented whenever rd is high and the FIFO is non-empty.
    always @(negedge clk) begin
        if (!reset && bus.rd && !bus.empty) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL pop_data: got %02h, required nothing (no word expected)", bus.r_data);
            end else begin
                logic [7:0] exp;
                exp = sb.pop_front();
                if (bus.r_data !== exp) begin
                    n_err++;
                    $display("FAIL pop_data: got %02h, required %02h", bus.r_data, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of {wr,rd}; exp_push says whether the write should be accepted.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic exp_push);
        bus.wr = w;
        bus.w_data = d;
        bus.rd = r;
        if (exp_push) sb.push_back(d);
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int cnt, input logic e, input logic f,
                              input logic o, input logic u);
        chk({tag, "_count"}, 32'(bus.count), 32'(cnt));
        chk({tag, "_empty"}, 32'(bus.empty), 32'(e));
        chk({tag, "_full"}, 32'(bus.full), 32'(f));
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(o));
        chk({tag, "_underflow"}, 32'(bus.underflow), 32'(u));
    endtask

    initial begin
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.w_data = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk_status("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Single word fall-through
        step(1'b1, 8'hA5, 1'b0, 1'b1);
        chk("fwft_data", 32'(bus.r_data), 32'h0000_00A5);
        chk_status("one", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("one_pop", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        chk_status("fill", 16, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk_status("ovf", 16, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("drain", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Pointer wrap-around
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b1);
        chk_status("wrap_fill", 12, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("wrap_drain", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Simultaneous read/write at empty and full
        step(1'b1, 8'h3C, 1'b1, 1'b1);
        chk("rw_empty_data", 32'(bus.r_data), 32'h0000_003C);
        chk_status("rw_empty", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b1);
        chk_status("refill", 16, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b1);
        chk("rw_full_head", 32'(bus.r_data), 32'h0000_0040);
        chk_status("rw_full", 16, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("rw_drain", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("udf", 0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset mid-stream with a write pending
        for (int i = 0; i < 7; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b1);
        chk_status("pre_rst", 7, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.wr = 1'b1;
        bus.w_data = 8'h99;
        do_reset();
        bus.wr = 1'b0;
        chk_status("mid_rst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h12, 1'b0, 1'b1);
        chk("post_rst_data", 32'(bus.r_data), 32'h0000_0012);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("post_rst", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
